// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants for the integer register file: instruction
//               field positions, write-back select codes, default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    localparam int REG_IDX_W = 5;
    localparam int RD_LSB    = 7;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;

    localparam int WB_SEL_W = 5;
    typedef logic [WB_SEL_W-1:0] wb_sel_t;

    localparam wb_sel_t WB_SEL_ALU = 5'd0;
    localparam wb_sel_t WB_SEL_MEM = 5'd1;

endpackage
`default_nettype wire

// File: rtl/reg_file_wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_mux
// Description : Combinational write-back source selector. Only WB_SEL_MEM
//               picks memory data; every other code falls back to the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb_mux
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wb_sel_t               i_sel,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_wb_data
);

    always_comb begin
        o_wb_data = i_alu_result;
        case (i_sel)
            WB_SEL_ALU: o_wb_data = i_alu_result;
            WB_SEL_MEM: o_wb_data = i_mem_data;
            default:    o_wb_data = i_alu_result;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 32-bit RISC-V integer register file, x0 hardwired to
//               zero, two combinational read ports, one write-back port.
//               Optional write-through forwarding: REG_FILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  wb_sel_t               mem_to_reg,
    input  logic [DATA_WIDTH-1:0] data_mem_data,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    logic [REG_IDX_W-1:0]                 w_rd;
    logic [REG_IDX_W-1:0]                 w_rs1;
    logic [REG_IDX_W-1:0]                 w_rs2;
    logic                                 w_wr_en;
    logic [DATA_WIDTH-1:0]                w_wb_data;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  w_regs;
    logic                                 w_unused_bits;

    assign w_rd  = instruction[RD_LSB  +: REG_IDX_W];
    assign w_rs1 = instruction[RS1_LSB +: REG_IDX_W];
    assign w_rs2 = instruction[RS2_LSB +: REG_IDX_W];

    // Opcode/funct fields are decoded elsewhere; writes are gated by reg_write.
    assign w_unused_bits = ^{instruction[31:25], instruction[14:12], instruction[6:0]};

    assign w_wr_en = reg_write && (w_rd != '0);

    reg_file_wb_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wb_mux (
        .i_sel        (mem_to_reg),
        .i_alu_result (alu_result),
        .i_mem_data   (data_mem_data),
        .o_wb_data    (w_wb_data)
    );

    assign w_regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_q <= '0;
            end else if (w_wr_en && (w_rd == REG_IDX_W'(i))) begin
                r_q <= w_wb_data;
            end
        end

        assign w_regs[i] = r_q;
    end

`ifdef REG_FILE_BYPASS_EN
    // w_wr_en already excludes x0, so x0 is never forwarded.
    assign rs1_data = (w_wr_en && rst && (w_rs1 == w_rd)) ? w_wb_data : w_regs[w_rs1];
    assign rs2_data = (w_wr_en && rst && (w_rs2 == w_rd)) ? w_wb_data : w_regs[w_rs2];
`else
    assign rs1_data = w_regs[w_rs1];
    assign rs2_data = w_regs[w_rs2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking bench for reg_file with an expected-
//               value queue filled at stimulus time and drained at readout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [4:0]  mem_to_reg;
    logic [31:0] data_mem_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .reg_write     (reg_write),
        .instruction   (instruction),
        .alu_result    (alu_result),
        .mem_to_reg    (mem_to_reg),
        .data_mem_data (data_mem_data),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed %h/%h", tag, rs1_data, rs2_data);
        end else begin
            e = sb.pop_front();
            check({tag, ".rs1"}, rs1_data, e.e1);
            check({tag, ".rs2"}, rs2_data, e.e2);
        end
    endtask

    // Combinational read: drive instruction, record expectation, sample 1ns later.
    task automatic do_read(input logic [31:0] instr, input logic [31:0] e1,
                           input logic [31:0] e2, input string tag);
        exp_t e;
        instruction = instr;
        reg_write   = 1'b0;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
        #1;
        check_pop(tag);
    endtask

    task automatic do_write(input logic [31:0] instr, input logic [4:0] sel,
                            input logic [31:0] alu, input logic [31:0] mem);
        instruction   = instr;
        mem_to_reg    = sel;
        alu_result    = alu;
        data_mem_data = mem;
        reg_write     = 1'b1;
        @(negedge clk);
        reg_write     = 1'b0;
    endtask

    function automatic logic [31:0] r_instr(input int rs1, input int rs2);
        logic [31:0] v;
        v = 32'h33;
        v[19:15] = rs1[4:0];
        v[24:20] = rs2[4:0];
        return v;
    endfunction

    function automatic logic [31:0] w_instr(input int rd);
        logic [31:0] v;
        v = 32'h33;
        v[11:7] = rd[4:0];
        return v;
    endfunction

    initial begin
        exp_t e;
        logic [31:0] bp_exp;

        rst           = 1'b1;
        reg_write     = 1'b0;
        instruction   = 32'h0;
        alu_result    = 32'h0;
        mem_to_reg    = 5'd0;
        data_mem_data = 32'h0;
        #1 rst = 1'b0;

        // Reset held for two cycles, every index reads zero.
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++)
            do_read(r_instr(i, 31 - i), 32'h0, 32'h0, $sformatf("reset_idx%0d", i));

        // Write attempt during reset is ignored.
        @(negedge clk);
        do_write(32'h000040b3, 5'd0, 32'h55, 32'h0);
        do_read(r_instr(1, 1), 32'h0, 32'h0, "write_in_reset");

        rst = 1'b1;
        @(negedge clk);

        // ALU write-back x1 = 1, read with rs1=x0, rs2=x1.
        do_write(32'h000040b3, 5'd0, 32'h1, 32'h0);
        do_read(32'h00100033, 32'h0, 32'h1, "alu_wb_x1");

        // Same-cycle write/read of x1: old value before the edge, new after.
        @(negedge clk);
        instruction = 32'h000080b3;
        mem_to_reg  = 5'd0;
        alu_result  = 32'h11;
        reg_write   = 1'b1;
`ifdef REG_FILE_BYPASS_EN
        bp_exp = 32'h11;
`else
        bp_exp = 32'h1;
`endif
        e.e1 = bp_exp;
        e.e2 = 32'h0;
        sb.push_back(e);
        #1;
        check_pop("rw_same_before");
        @(negedge clk);
        reg_write = 1'b0;
        do_read(r_instr(1, 0), 32'h11, 32'h0, "rw_same_after");

        // x0 protection.
        @(negedge clk);
        do_write(32'h00000033, 5'd0, 32'h3, 32'h0);
        do_read(32'h00000033, 32'h0, 32'h0, "x0_protect");

        // Back-to-back writes x5=5 then x6=6.
        @(negedge clk);
        do_write(32'h006282b3, 5'd0, 32'h5, 32'h0);
        do_write(32'h00628333, 5'd0, 32'h6, 32'h0);
        do_read(32'h006282b3, 32'h5, 32'h6, "back_to_back");

        // Memory source, then a reserved select code falls back to ALU.
        @(negedge clk);
        do_write(w_instr(2), 5'd1, 32'h7, 32'hDEADBEEF);
        do_read(r_instr(2, 0), 32'hDEADBEEF, 32'h0, "mem_src_x2");
        @(negedge clk);
        do_write(w_instr(2), 5'd2, 32'h7, 32'hDEADBEEF);
        do_read(r_instr(2, 2), 32'h7, 32'h7, "sel2_alu_x2");
        @(negedge clk);
        do_write(w_instr(3), 5'd31, 32'hA5A5_0003, 32'h1234_5678);
        do_read(r_instr(0, 3), 32'h0, 32'hA5A5_0003, "sel31_alu_x3");

        // Fill x1..x6 then clear asynchronously between edges.
        @(negedge clk);
        for (int i = 1; i <= 6; i++)
            do_write(w_instr(i), 5'd0, 32'h100 + i, 32'h0);
        do_read(r_instr(1, 6), 32'h101, 32'h106, "fill_x1_x6");
        do_read(r_instr(3, 4), 32'h103, 32'h104, "fill_x3_x4");

        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 1; i <= 6; i++)
            do_read(r_instr(i, 7 - i), 32'h0, 32'h0, $sformatf("async_clr_x%0d", i));

        // Pending write across an edge while in reset is lost; no forwarding either.
        @(negedge clk);
        instruction = 32'h000181b3;
        mem_to_reg  = 5'd0;
        alu_result  = 32'h77;
        reg_write   = 1'b1;
        e.e1 = 32'h0;
        e.e2 = 32'h0;
        sb.push_back(e);
        #1;
        check_pop("rst_pending_before");
        @(negedge clk);
        reg_write = 1'b0;
        do_read(r_instr(3, 3), 32'h0, 32'h0, "rst_pending_after");

        rst = 1'b1;
        @(negedge clk);

        // Same-cycle write/read of x5=9 on both ports.
        instruction = 32'h005282b3;
        mem_to_reg  = 5'd0;
        alu_result  = 32'h9;
        reg_write   = 1'b1;
`ifdef REG_FILE_BYPASS_EN
        bp_exp = 32'h9;
`else
        bp_exp = 32'h0;
`endif
        e.e1 = bp_exp;
        e.e2 = bp_exp;
        sb.push_back(e);
        #1;
        check_pop("x5_same_before");
        @(negedge clk);
        reg_write = 1'b0;
        do_read(r_instr(5, 0), 32'h9, 32'h0, "x5_same_after");

        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Integer register file of the single-cycle RISC-V core: 32 × 32-bit general-purpose registers, x0 hardwired to zero. Decodes rd/rs1/rs2 directly from the current instruction word. Provides two combinational read ports feeding the ALU and branch logic. Accepts one synchronous write-back per cycle, with the write data selected between the ALU result and data-memory read data.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data-bus width; only 32 is supported.
- NUM_REGS, 32, number of architectural registers; index width is 5.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- reg_write  in  1  write enable for the rd write-back
- instruction  in  32  current instruction; rd=[11:7], rs1=[19:15], rs2=[24:20]
- alu_result  in  32  ALU write-back source
- mem_to_reg  in  5  write-back source select
- data_mem_data  in  32  data-memory write-back source
- rs1_data  out  32  contents of register rs1
- rs2_data  out  32  contents of register rs2

## Operation
- Write-back mux: mem_to_reg==5'd1 selects data_mem_data. Every other value, including 0 and the reserved 2..31, selects alu_result.
- Write: if reg_write=1 and rd≠0, reg[rd] ← the selected write-back data.
- x0: writes to x0 are discarded. Reading index 0 always returns 32'h0.
- Reads: rs1_data = reg[rs1] and rs2_data = reg[rs2], purely combinational from instruction and array state.
- Reset: while rst=0, all registers are 0 and writes are ignored. rs1_data and rs2_data therefore read 0.
- Opcode bits are ignored. Gating writes is the caller's job via reg_write.

## Timing
- Reset asserts asynchronously: the array clears immediately when rst falls, without waiting for a clock edge.
- Reset is released synchronously with respect to writes. The first write can occur on the first rising edge after rst=1.
- Write latency: data is captured on the rising clk edge and is visible on the read ports after that edge.
- Reading and writing the same register in one cycle returns the old value before the edge and the new value after it (no bypass unless configured).
- Reset mid-operation: any pending write on the same edge is lost, and the array stays 0.
- Back-to-back writes to different registers on consecutive cycles are all retained.

## Configuration
- REG_FILE_BYPASS_EN defined: if reg_write=1, rst=1, rd≠0 and rd equals rs1 or rs2, the matching read port returns the current write-back data combinationally (write-through forwarding). x0 is never bypassed.
- Not defined: read ports return the stored array contents only.

## Structure
- Package reg_file_pkg holds:
  - instruction field bit positions (RD_LSB=7, RS1_LSB=15, RS2_LSB=20, field width 5)
  - WB_SEL_ALU=5'd0 and WB_SEL_MEM=5'd1
  - DATA_WIDTH and NUM_REGS defaults
- One sub-module, reg_file_wb_mux: the combinational write-back source selector.
- The array and read logic stay in the top module.

## Test plan
- Reset: hold rst=0 for two cycles and read all 32 indices -> every read returns 32'h0. Attempt a write with reg_write=1 during reset -> nothing is stored.
- ALU write-back: rst=1, instruction=32'h000040b3, alu_result=1, mem_to_reg=0, reg_write=1 for one edge, then instruction=32'h00100033 (rs1=x0, rs2=x1) -> rs2_data=32'h1, rs1_data=0.
- x0 protection: instruction=32'h00000033, alu_result=3, reg_write=1 for one edge -> reading x0 returns 0.
- Back-to-back writes: write x5=5 (32'h006282b3), next cycle x6=6 (32'h00628333), then deassert reg_write and read with 32'h006282b3 -> rs1_data=5, rs2_data=6.
- Memory source: mem_to_reg=1, data_mem_data=32'hDEADBEEF, alu_result=7, write x2 -> x2 reads 32'hDEADBEEF. Then mem_to_reg=2 with alu_result=7 -> x2 reads 7.
- Reset mid-run: after filling x1..x6, drop rst asynchronously between clock edges -> all reads return 0 immediately. With REG_FILE_BYPASS_EN, a same-cycle write/read of x5=9 returns 9 before the edge.
